pulse_monitor: RTL

Downstream consumer of the single-bit `and_gate` output in the example benches. It samples the gate output every clock and counts rising edges. It measures the width of each high pulse in clock cycles and queues one record per completed pulse in a small FIFO. Records drain through a valid/ready port to the bench, so tests can check pulse timing instead of printing raw values each cycle.

---
 rtl/pulse_monitor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pulse_monitor.sv
// Counts rising edges of sig_in, measures each high pulse and queues {sat, width} records in a small FIFO.
// Latency: one cycle from the first low sample to rec_valid; a full FIFO drops the record unless a pop happens that cycle.
module pulse_monitor #(
   parameter int WIDTH_W = 8,
   parameter int CNT_W   = 16,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sig_in,
   output logic               rec_valid,
   input  logic               rec_ready,
   output logic [WIDTH_W-1:0] rec_width,
   output logic               rec_sat,
   output logic [CNT_W-1:0]   edge_count,
   output logic [CNT_W-1:0]   drop_count,
   output logic               overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic               sat;
      logic [WIDTH_W-1:0] width;
   } rec_t;

   typedef enum logic [1:0] {ARM, IDLE, HIGH} state_t;

   state_t             state, state_nxt;
   logic [WIDTH_W-1:0] width_cnt;
   logic               width_sat;

   rec_t               mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr, rd_nxt;
   logic [CW-1:0]      count, count_nxt;
   logic               pop, push_req, push, rise;
   rec_t               new_rec;

   always_ff @(posedge clk) begin
      if (rst) state <= ARM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARM:     if (!sig_in) state_nxt = IDLE;
         IDLE:    if (sig_in)  state_nxt = HIGH;
         HIGH:    if (!sig_in) state_nxt = IDLE;
         default: state_nxt = ARM;
      endcase
   end

   always_comb begin
      rise      = (state == IDLE) && sig_in;
      push_req  = (state == HIGH) && !sig_in;
      pop       = rec_valid && rec_ready;
      // A full FIFO still takes the record when the head leaves in the same cycle.
      push      = push_req && ((count != CW'(DEPTH)) || pop);
      count_nxt = count + CW'(push) - CW'(pop);
      rd_nxt    = rd_ptr + AW'(pop);
      new_rec   = '{sat: width_sat, width: width_cnt};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         width_cnt  <= '0;
         width_sat  <= 1'b0;
         edge_count <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (rise) begin
            width_cnt <= WIDTH_W'(1);
            width_sat <= 1'b0;
            if (edge_count != '1) edge_count <= edge_count + 1'b1;
         end else if (state == HIGH && sig_in) begin
            if (width_cnt != '1) width_cnt <= width_cnt + 1'b1;
            else                 width_sat <= 1'b1;
         end
         if (push_req && !push) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= new_rec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rec_valid <= 1'b0;
         rec_width <= '0;
         rec_sat   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_nxt;
         count  <= count_nxt;
         // Head register: bypass the incoming record when it becomes the only entry.
         if (count_nxt == '0) begin
            rec_valid <= 1'b0;
            rec_width <= '0;
            rec_sat   <= 1'b0;
         end else if ((count - CW'(pop)) == '0) begin
            rec_valid <= 1'b1;
            rec_width <= new_rec.width;
            rec_sat   <= new_rec.sat;
         end else begin
            rec_valid <= 1'b1;
            rec_width <= mem[rd_nxt].width;
            rec_sat   <= mem[rd_nxt].sat;
         end
      end
   end

endmodule
